// File: rtl/axi_wr_limit.sv
// AXI4 write-burst limiter with wlast regeneration from awlen.
// Define AXI_WR_LIMIT_WLAST_CHECK_EN to add the sticky status_wlast_err output.

// Generic synchronous FIFO, DEPTH entries of WIDTH bits.
// Latency: one cycle from accepted write to rd_vld.
// Backpressure: wr_rdy low when full; rd_vld low when empty.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_vld,
    output logic             wr_rdy,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             rd_vld,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    assign wr_rdy = (count != CW'(DEPTH));
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];
    assign do_wr  = wr_vld && wr_rdy;
    assign do_rd  = rd_vld && rd_rdy;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// Limits accepted-but-unresponded write bursts and regenerates wlast per burst.
// Latency: AW/W/B payloads combinational; a burst's W opens two cycles after its AW handshake.
// Backpressure: AW stalls at MAX_OUTSTANDING; W held off until its AW is accepted downstream.
module axi_wr_limit #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int ID_WIDTH        = 8,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic [3:0]            s_axi_awqos,
    input  logic [3:0]            s_axi_awregion,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic [3:0]            m_axi_awqos,
    output logic [3:0]            m_axi_awregion,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] status_outstanding
`ifdef AXI_WR_LIMIT_WLAST_CHECK_EN
    ,
    output logic                  status_wlast_err
`endif
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [0:0] W_IDLE  = 1'b0;
    localparam logic [0:0] W_BURST = 1'b1;

    logic [CW-1:0] outstanding;
    logic          stall;
    logic          aw_hs;
    logic          b_hs;
    logic          b_dec;
    logic          w_hs;
    logic          burst_done;
    logic [0:0]    w_state;
    logic [7:0]    beat_remaining;
    logic          q_vld;
    logic [7:0]    q_len;
    logic          unused_q_rdy;

    assign stall          = (outstanding == CW'(MAX_OUTSTANDING));
    assign m_axi_awvalid  = s_axi_awvalid && !stall;
    assign s_axi_awready  = m_axi_awready && !stall;
    assign aw_hs          = m_axi_awvalid && m_axi_awready;
    assign m_axi_awid     = s_axi_awid;
    assign m_axi_awaddr   = s_axi_awaddr;
    assign m_axi_awlen    = s_axi_awlen;
    assign m_axi_awsize   = s_axi_awsize;
    assign m_axi_awburst  = s_axi_awburst;
    assign m_axi_awlock   = s_axi_awlock;
    assign m_axi_awcache  = s_axi_awcache;
    assign m_axi_awprot   = s_axi_awprot;
    assign m_axi_awqos    = s_axi_awqos;
    assign m_axi_awregion = s_axi_awregion;

    assign s_axi_bid    = m_axi_bid;
    assign s_axi_bresp  = m_axi_bresp;
    assign s_axi_bvalid = m_axi_bvalid;
    assign m_axi_bready = s_axi_bready;
    assign b_hs         = m_axi_bvalid && s_axi_bready;
    // A response with nothing outstanding is absorbed rather than wrapping the count
    assign b_dec        = b_hs && (outstanding != '0);

    assign status_outstanding = outstanding;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding <= '0;
        end else if (aw_hs && !b_dec) begin
            outstanding <= outstanding + CW'(1);
        end else if (b_dec && !aw_hs) begin
            outstanding <= outstanding - CW'(1);
        end
    end

    fifo #(
        .WIDTH (8),
        .DEPTH (MAX_OUTSTANDING)
    ) u_len_q (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_vld (aw_hs),
        .wr_rdy (unused_q_rdy),
        .wr_dat (s_axi_awlen),
        .rd_vld (q_vld),
        .rd_rdy (burst_done),
        .rd_dat (q_len)
    );

    assign m_axi_wdata  = s_axi_wdata;
    assign m_axi_wstrb  = s_axi_wstrb;
    assign m_axi_wvalid = (w_state == W_BURST) && s_axi_wvalid;
    assign s_axi_wready = (w_state == W_BURST) && m_axi_wready;
    assign m_axi_wlast  = (w_state == W_BURST) && (beat_remaining == 8'd0);
    assign w_hs         = m_axi_wvalid && m_axi_wready;
    assign burst_done   = w_hs && m_axi_wlast;

    // Head length stays queued until its last beat, so it is popped exactly once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state        <= W_IDLE;
            beat_remaining <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (q_vld) begin
                        beat_remaining <= q_len;
                        w_state        <= W_BURST;
                    end
                end
                W_BURST: begin
                    if (w_hs) begin
                        if (beat_remaining == 8'd0) begin
                            w_state <= W_IDLE;
                        end else begin
                            beat_remaining <= beat_remaining - 8'd1;
                        end
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

`ifdef AXI_WR_LIMIT_WLAST_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_wlast_err <= 1'b0;
        end else if (w_hs && (s_axi_wlast != m_axi_wlast)) begin
            status_wlast_err <= 1'b1;
        end
    end
`else
    logic unused_wlast;
    assign unused_wlast = s_axi_wlast;
`endif
endmodule

// File: tb/tb_axi_wr_limit.sv
// Bench for axi_wr_limit: directed scenarios followed by random traffic, checked by a queue model.
module tb_axi_wr_limit;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;
    localparam int IW = 8;
    localparam int MO = 2;
    localparam int CW = $clog2(MO + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [IW-1:0] s_axi_awid, m_axi_awid, m_axi_bid, s_axi_bid;
    logic [AW-1:0] s_axi_awaddr, m_axi_awaddr;
    logic [7:0]    s_axi_awlen, m_axi_awlen;
    logic [2:0]    s_axi_awsize, m_axi_awsize, s_axi_awprot, m_axi_awprot;
    logic [1:0]    s_axi_awburst, m_axi_awburst, m_axi_bresp, s_axi_bresp;
    logic          s_axi_awlock, m_axi_awlock;
    logic [3:0]    s_axi_awcache, m_axi_awcache, s_axi_awqos, m_axi_awqos;
    logic [3:0]    s_axi_awregion, m_axi_awregion;
    logic          s_axi_awvalid, s_axi_awready, m_axi_awvalid, m_axi_awready;
    logic [DW-1:0] s_axi_wdata, m_axi_wdata;
    logic [SW-1:0] s_axi_wstrb, m_axi_wstrb;
    logic          s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic          m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic          m_axi_bvalid, m_axi_bready, s_axi_bvalid, s_axi_bready;
    logic [CW-1:0] status_outstanding;
`ifdef AXI_WR_LIMIT_WLAST_CHECK_EN
    logic          status_wlast_err;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference model: outstanding count, queue of burst lengths, beat position in the open burst
    int m_cnt;
    int m_q[$];
    bit m_act;
    int m_beat;
    int m_bpend;
    bit m_err;

    axi_wr_limit #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW), .ID_WIDTH(IW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_awregion(s_axi_awregion), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awregion(m_axi_awregion), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .status_outstanding(status_outstanding)
`ifdef AXI_WR_LIMIT_WLAST_CHECK_EN
        , .status_wlast_err(status_wlast_err)
`endif
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_awburst = '0; s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0;
        s_axi_awqos = '0; s_axi_awregion = '0; s_axi_awvalid = 1'b0; m_axi_awready = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        m_axi_wready = 1'b0; m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;
        s_axi_bready = 1'b0;
    endtask

    task automatic model_reset();
        m_cnt = 0; m_q.delete(); m_act = 0; m_beat = 0; m_bpend = 0; m_err = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        clear_inputs();
        #1;
        chk("rst_awready_lo", s_axi_awready, 1'b0);
        m_axi_awready = 1'b1; s_axi_wvalid = 1'b1; m_axi_wready = 1'b1;
        #1;
        chk("rst_awready_hi", s_axi_awready, 1'b1);
        chk("rst_outstanding", status_outstanding, 0);
        chk("rst_wvalid", m_axi_wvalid, 1'b0);
        chk("rst_wready", s_axi_wready, 1'b0);
`ifdef AXI_WR_LIMIT_WLAST_CHECK_EN
        chk("rst_wlast_err", status_wlast_err, 1'b0);
`endif
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called just after a negedge with inputs applied; checks, crosses one posedge, returns at negedge
    task automatic step();
        bit exp_awrdy, exp_last, aw_hs, w_hs, b_hs, was_ne;
        #1;
        exp_awrdy = m_axi_awready && (m_cnt < MO);
        exp_last  = m_act ? (m_beat == m_q[0]) : 1'b0;
        chk("awready", s_axi_awready, exp_awrdy);
        chk("awvalid", m_axi_awvalid, s_axi_awvalid && (m_cnt < MO));
        chk("aw_fields",
            {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
             m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion},
            {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awlock,
             s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion});
        chk("wvalid", m_axi_wvalid, m_act && s_axi_wvalid);
        chk("wready", s_axi_wready, m_act && m_axi_wready);
        chk("wlast", m_axi_wlast, exp_last);
        chk("w_fields", {m_axi_wdata, m_axi_wstrb}, {s_axi_wdata, s_axi_wstrb});
        chk("b_fields", {s_axi_bid, s_axi_bresp, s_axi_bvalid, m_axi_bready},
            {m_axi_bid, m_axi_bresp, m_axi_bvalid, s_axi_bready});
        chk("outstanding", status_outstanding, m_cnt);
`ifdef AXI_WR_LIMIT_WLAST_CHECK_EN
        chk("wlast_err", status_wlast_err, m_err);
`endif
        aw_hs = s_axi_awvalid && exp_awrdy;
        w_hs  = m_act && s_axi_wvalid && m_axi_wready;
        b_hs  = m_axi_bvalid && s_axi_bready;
        @(posedge clk);
        was_ne = (m_q.size() != 0);
        if (w_hs && (s_axi_wlast != exp_last)) m_err = 1;
        if (w_hs) begin
            if (exp_last) begin
                void'(m_q.pop_front());
                m_act = 0;
                m_bpend++;
            end else begin
                m_beat++;
            end
        end else if (!m_act && was_ne) begin
            m_act = 1;
            m_beat = 0;
        end
        if (aw_hs) m_q.push_back(int'(s_axi_awlen));
        if (aw_hs && !(b_hs && m_cnt > 0)) m_cnt++;
        else if (!aw_hs && b_hs && m_cnt > 0) m_cnt--;
        if (b_hs && m_bpend > 0) m_bpend--;
        @(negedge clk);
    endtask

    task automatic b_pulse();
        m_axi_bvalid = 1'b1; s_axi_bready = 1'b1;
        step();
        m_axi_bvalid = 1'b0; s_axi_bready = 1'b0;
    endtask

    initial begin
        clear_inputs();
        do_reset();

        // Response with nothing outstanding leaves the count at zero
        b_pulse();
        #1 chk("b_at_zero", status_outstanding, 0);

        // W offered before any AW stays blocked until the AW is in and one cycle has passed
        s_axi_wvalid = 1'b1; m_axi_wready = 1'b1; s_axi_wdata = 32'hA5A5_0001; s_axi_wlast = 1'b1;
        repeat (3) begin
            #1 chk("early_wready", s_axi_wready, 1'b0);
            step();
        end
        s_axi_awvalid = 1'b1; m_axi_awready = 1'b1; s_axi_awlen = 8'd0;
        step();
        s_axi_awvalid = 1'b0;
        #1 chk("bubble_wready", s_axi_wready, 1'b0);
        step();
        #1 chk("first_wready", s_axi_wready, 1'b1);
        chk("first_wlast", m_axi_wlast, 1'b1);
        step();
        s_axi_wvalid = 1'b0;
        b_pulse();

        // Two single-beat bursts fill the limit; the third AW stalls until a response returns
        s_axi_awvalid = 1'b1; s_axi_awlen = 8'd0; s_axi_wvalid = 1'b1; s_axi_wlast = 1'b1;
        step();
        step();
        #1 chk("stall_awready", s_axi_awready, 1'b0);
        chk("stall_awvalid", m_axi_awvalid, 1'b0);
        chk("stall_count", status_outstanding, 2);
        step();
        b_pulse();
        #1 chk("unstall_awready", s_axi_awready, 1'b1);
        step();
        s_axi_awvalid = 1'b0;
        #1 chk("unstall_count", status_outstanding, 2);
        repeat (3) step();
        s_axi_wvalid = 1'b0;
        b_pulse();
        b_pulse();
        #1 chk("drained_count", status_outstanding, 0);

        // Four-beat burst: wlast regenerated on beat 4 only, then back to idle
        s_axi_wlast = 1'b0; s_axi_awvalid = 1'b1; s_axi_awlen = 8'd3;
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            s_axi_wdata = $urandom;
`ifdef AXI_WR_LIMIT_WLAST_CHECK_EN
            s_axi_wlast = (i == 3);
`endif
            #1 chk("len3_wlast", m_axi_wlast, (i == 3));
            chk("len3_wready", s_axi_wready, 1'b1);
            step();
        end
        #1 chk("len3_idle_wready", s_axi_wready, 1'b0);
        step();
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        b_pulse();

`ifdef AXI_WR_LIMIT_WLAST_CHECK_EN
        // Early wlast on a two-beat burst sets the sticky error
        #1 chk("err_before", status_wlast_err, 1'b0);
        s_axi_awvalid = 1'b1; s_axi_awlen = 8'd1;
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b1; s_axi_wlast = 1'b1;
        step();
        step();
        step();
        #1 chk("err_set", status_wlast_err, 1'b1);
        s_axi_wvalid = 1'b0;
        repeat (3) step();
        #1 chk("err_sticky", status_wlast_err, 1'b1);
        b_pulse();
`endif

        do_reset();

        for (int c = 0; c < 1500; c++) begin
            s_axi_awvalid  = 1'($urandom_range(0, 1));
            s_axi_awid     = 8'($urandom);
            s_axi_awaddr   = $urandom;
            s_axi_awlen    = 8'($urandom_range(0, 3));
            s_axi_awsize   = 3'($urandom);
            s_axi_awburst  = 2'($urandom);
            s_axi_awlock   = 1'($urandom);
            s_axi_awcache  = 4'($urandom);
            s_axi_awprot   = 3'($urandom);
            s_axi_awqos    = 4'($urandom);
            s_axi_awregion = 4'($urandom);
            m_axi_awready  = ($urandom_range(0, 3) != 0);
            s_axi_wvalid   = 1'($urandom_range(0, 1));
            s_axi_wdata    = $urandom;
            s_axi_wstrb    = 4'($urandom);
            s_axi_wlast    = 1'($urandom_range(0, 1));
            m_axi_wready   = ($urandom_range(0, 3) != 0);
            m_axi_bvalid   = (m_bpend > 0) && ($urandom_range(0, 1) == 1);
            m_axi_bid      = 8'($urandom);
            m_axi_bresp    = 2'($urandom);
            s_axi_bready   = 1'($urandom_range(0, 1));
            step();
        end

        // Reset asserted during beat 2 of a four-beat burst
        do_reset();
        m_axi_awready = 1'b1; s_axi_awvalid = 1'b1; s_axi_awlen = 8'd3;
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b1; m_axi_wready = 1'b1;
        step();
        step();
        #1 chk("mid_wvalid_before", m_axi_wvalid, 1'b1);
        rst_n = 1'b0;
        #1 chk("rst_mid_count", status_outstanding, 0);
        chk("rst_mid_wvalid", m_axi_wvalid, 1'b0);
        do_reset();
        s_axi_wvalid = 1'b1; m_axi_wready = 1'b1;
        repeat (3) begin
            #1 chk("post_rst_wready", s_axi_wready, 1'b0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/axi_wr_limit.md
AXI_WR_LIMIT -- requirements
Module: axi_wr_limit

Interface
REQ-001 DATA_WIDTH, 32, W data width in bits.
REQ-002 ADDR_WIDTH, 32, AW address width in bits.
REQ-003 STRB_WIDTH, DATA_WIDTH/8, wstrb width.
REQ-004 ID_WIDTH, 8, awid/bid width.
REQ-005 MAX_OUTSTANDING, 16, maximum accepted-but-unresponded write bursts; legal range 1..256.
REQ-006 clk  input  1  sole clock, rising edge.
REQ-007 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-008 s_axi_aw{id,addr,len[7:0],size,burst,lock,cache,prot,qos,region}  input  AXI4 widths  slave AW payload; each field passes combinationally to the matching m_axi_aw* output.
REQ-009 s_axi_awvalid  input  1; s_axi_awready  output  1; m_axi_awvalid  output  1; m_axi_awready  input  1.
REQ-010 s_axi_wdata/wstrb  input  DATA_WIDTH/STRB_WIDTH; s_axi_wlast  input  1; s_axi_wvalid  input  1; s_axi_wready  output  1.
REQ-011 m_axi_wdata/wstrb  output  DATA_WIDTH/STRB_WIDTH; m_axi_wlast  output  1; m_axi_wvalid  output  1; m_axi_wready  input  1.
REQ-012 m_axi_bid/bresp  input  ID_WIDTH/2; m_axi_bvalid  input  1; m_axi_bready  output  1; s_axi_bid/bresp/bvalid  output; s_axi_bready  input.
REQ-013 status_outstanding  output  $clog2(MAX_OUTSTANDING+1)  current outstanding burst count.

Function
REQ-014 Sits upstream of the write-data FIFO; limits in-flight bursts and regenerates wlast from awlen.
REQ-015 stall = (outstanding == MAX_OUTSTANDING); m_axi_awvalid = s_axi_awvalid && !stall; s_axi_awready = m_axi_awready && !stall.
REQ-016 AW handshake (m_axi_awvalid && m_axi_awready) increments outstanding and pushes awlen into a length queue of depth MAX_OUTSTANDING.
REQ-017 B handshake (m_axi_bvalid && s_axi_bready) decrements outstanding; same-cycle AW and B handshakes leave count unchanged; B channel is a combinational bypass.
REQ-018 outstanding never exceeds MAX_OUTSTANDING nor underflows; B handshake at zero leaves count at 0.
REQ-019 W FSM states W_IDLE, W_BURST; reset state W_IDLE.
REQ-020 W_IDLE: s_axi_wready = 0, m_axi_wvalid = 0; if queue non-empty, load head len into beat_remaining, go W_BURST next cycle.
REQ-021 W_BURST: m_axi_wvalid = s_axi_wvalid; s_axi_wready = m_axi_wready; data/strb pass combinationally; m_axi_wlast = (beat_remaining == 0).
REQ-022 Each W handshake in W_BURST decrements beat_remaining; handshake with beat_remaining == 0 pops the queue and returns to W_IDLE (one bubble cycle between bursts).
REQ-023 Same-cycle queue push and pop both take effect; push when queue full cannot occur (guarded by stall).
REQ-024 W beats never pass before their AW is accepted downstream.

Reset
REQ-025 rst_n low: outstanding = 0, queue empty, FSM W_IDLE, beat_remaining = 0; hence s_axi_awready = 0 only if m_axi_awready = 0, m_axi_wvalid = 0, s_axi_wready = 0.
REQ-026 Reset mid-burst discards queued lengths and counts; no recovery of in-flight transactions.

Configuration
REQ-027 Macro AXI_WR_LIMIT_WLAST_CHECK_EN: when defined, adds output status_wlast_err (1 bit), set sticky when a W handshake has s_axi_wlast != generated m_axi_wlast, cleared only by reset.
REQ-028 Without the macro, status_wlast_err does not exist and s_axi_wlast is ignored.

Verification
REQ-029 MAX_OUTSTANDING=2, three AWs len=0, bready=0 -> third AW stalls (s_axi_awready=0), status_outstanding=2.
REQ-030 Then one B handshake -> third AW accepted next cycle, count stays 2.
REQ-031 AW len=3, four W beats with s_axi_wlast=0 -> m_axi_wlast=1 only on beat 4, FSM returns W_IDLE.
REQ-032 W valid before any AW -> s_axi_wready=0 until AW handshake plus one cycle.
REQ-033 Macro defined, AW len=1, wlast asserted on beat 1 -> status_wlast_err=1 and stays 1.
REQ-034 rst_n pulsed low mid-burst (beat 2 of 4) -> status_outstanding=0, m_axi_wvalid=0 immediately.
